// File: rtl/pipe_seq_ctrl_if.sv
// Control bundle between the hazard-detection logic and the pipeline sequencer.
// Every signal is a level that is valid for the whole cycle it is driven in. There is no valid/ready handshake.
interface pipe_seq_ctrl_if;
    logic       stall_req;
    logic       md_start;
    logic       md_div;
    logic       md_use_D;
    logic       exc_req;
    logic       eret_D;
    logic       en_F;
    logic       en_D;
    logic       en_E;
    logic       flush_D;
    logic       flush_E;
    logic       flush_M;
    logic [1:0] pc_sel;
    logic       md_busy;
    logic [1:0] state;

    modport master (
        output stall_req, md_start, md_div, md_use_D, exc_req, eret_D,
        input  en_F, en_D, en_E, flush_D, flush_E, flush_M, pc_sel, md_busy, state
    );

    modport slave (
        input  stall_req, md_start, md_div, md_use_D, exc_req, eret_D,
        output en_F, en_D, en_E, flush_D, flush_E, flush_M, pc_sel, md_busy, state
    );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: stalls, flushes and next-PC selection for exceptions, eret and
// the multi-cycle HI/LO unit. The state is registered and the outputs are combinational.
module pipe_seq_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic           clk,
    input  logic           reset,
    pipe_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_MDWAIT = 2'b01,
        S_EXC    = 2'b10,
        S_ERET   = 2'b11
    } state_t;

    localparam logic [1:0] PC_SEQ     = 2'b00;
    localparam logic [1:0] PC_HANDLER = 2'b01;
    localparam logic [1:0] PC_EPC     = 2'b10;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] count_q;
    logic       md_busy;
    logic       md_hazard;

    logic       en_f, en_d, flush_d, flush_e, flush_m;
    logic [1:0] pc_sel;

    assign md_busy   = (count_q != 4'd0);
    assign md_hazard = bus.md_use_D & (md_busy | bus.md_start);

    always_comb begin
        state_d = state_q;
        en_f    = 1'b1;
        en_d    = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        pc_sel  = PC_SEQ;
        // While reset is held, the outputs stay at their idle values whatever the inputs are.
        if (reset) begin
            case (state_q)
                S_RUN: begin
                    if (bus.exc_req) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                        flush_m = 1'b1;
                        pc_sel  = PC_HANDLER;
                        state_d = S_EXC;
                    end else if (bus.eret_D) begin
                        flush_d = 1'b1;
                        pc_sel  = PC_EPC;
                        state_d = S_ERET;
                    end else if (md_hazard) begin
                        en_f    = 1'b0;
                        en_d    = 1'b0;
                        flush_e = 1'b1;
                        state_d = S_MDWAIT;
                    end else if (bus.stall_req) begin
                        en_f    = 1'b0;
                        en_d    = 1'b0;
                        flush_e = 1'b1;
                    end
                end
                S_MDWAIT: begin
                    if (bus.exc_req) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                        flush_m = 1'b1;
                        pc_sel  = PC_HANDLER;
                        state_d = S_EXC;
                    end else if (md_busy) begin
                        en_f    = 1'b0;
                        en_d    = 1'b0;
                        flush_e = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                // The fetch issued under the old PC is on the wrong path, so it is discarded.
                S_EXC: begin
                    flush_d = 1'b1;
                    state_d = S_RUN;
                end
                S_ERET: begin
                    flush_d = 1'b1;
                    if (bus.exc_req) begin
                        flush_e = 1'b1;
                        flush_m = 1'b1;
                        pc_sel  = PC_HANDLER;
                        state_d = S_EXC;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            // A mult/div already in flight finishes. A new issue and exceptions do not disturb it.
            if (bus.md_start && !md_busy) begin
                count_q <= bus.md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
            end else if (md_busy) begin
                count_q <= count_q - 4'd1;
            end
        end
    end

    assign bus.en_F    = en_f;
    assign bus.en_D    = en_d;
    assign bus.en_E    = 1'b1;
    assign bus.flush_D = flush_d;
    assign bus.flush_E = flush_e;
    assign bus.flush_M = flush_m;
    assign bus.pc_sel  = pc_sel;
    assign bus.md_busy = md_busy;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: directed scenarios followed by random traffic, checked
// against a flag/counter model of the sequencing rules through an expected-value queue.
module tb_pipe_seq_ctrl;
  localparam int W = 11;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC = 10;

  logic clk;
  logic reset;
  pipe_seq_ctrl_if bus();

  pipe_seq_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: pending one-cycle shadows, an md-wait flag and cycles left on HI/LO
  bit m_exc_shadow = 0;
  bit m_eret_shadow = 0;
  bit m_md_wait = 0;
  int m_md_left = 0;

  function automatic logic [W-1:0] pack(input logic [1:0] st, input bit busy, input logic [1:0] pc,
                                        input bit fd, input bit fe, input bit fm,
                                        input bit ef, input bit ed, input bit ee);
    return {st, busy, pc, fd, fe, fm, ef, ed, ee};
  endfunction

  // driver: inputs change 1 time unit after the rising edge, expectation pushed for that cycle
  task automatic drive(input bit rst_n_v, input bit st, input bit ms, input bit md,
                       input bit mu, input bit ex, input bit er);
    logic [1:0] e_state, e_pc;
    bit e_fd, e_fe, e_fm, e_ef, e_ed, busy, hz;
    bit nx_exc, nx_eret, nx_wait;
    @(posedge clk);
    #1;
    reset = rst_n_v;
    bus.stall_req = st;
    bus.md_start = ms;
    bus.md_div = md;
    bus.md_use_D = mu;
    bus.exc_req = ex;
    bus.eret_D = er;

    e_state = 2'b00; e_pc = 2'b00;
    e_fd = 0; e_fe = 0; e_fm = 0; e_ef = 1; e_ed = 1;
    nx_exc = 0; nx_eret = 0; nx_wait = 0;
    busy = (m_md_left > 0);
    hz = mu && (busy || ms);
    if (!rst_n_v) begin
      busy = 0;
    end else if (m_exc_shadow) begin
      e_state = 2'b10; e_fd = 1;
    end else if (ex) begin
      e_state = m_eret_shadow ? 2'b11 : (m_md_wait ? 2'b01 : 2'b00);
      e_fd = 1; e_fe = 1; e_fm = 1; e_pc = 2'b01; nx_exc = 1;
    end else if (m_eret_shadow) begin
      e_state = 2'b11; e_fd = 1;
    end else if (m_md_wait) begin
      e_state = 2'b01;
      if (busy) begin
        e_ef = 0; e_ed = 0; e_fe = 1; nx_wait = 1;
      end
    end else if (er) begin
      e_pc = 2'b10; e_fd = 1; nx_eret = 1;
    end else if (hz) begin
      e_ef = 0; e_ed = 0; e_fe = 1; nx_wait = 1;
    end else if (st) begin
      e_ef = 0; e_ed = 0; e_fe = 1;
    end
    exp_q.push_back(pack(e_state, busy, e_pc, e_fd, e_fe, e_fm, e_ef, e_ed, 1'b1));

    if (!rst_n_v) m_md_left = 0;
    else if (ms && m_md_left == 0) m_md_left = md ? DIV_CYC : MULT_CYC;
    else if (m_md_left > 0) m_md_left = m_md_left - 1;
    m_exc_shadow = nx_exc;
    m_eret_shadow = nx_eret;
    m_md_wait = nx_wait;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: samples on the falling edge, mid-cycle
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act = {bus.state, bus.md_busy, bus.pc_sel, bus.flush_D, bus.flush_E, bus.flush_M,
             bus.en_F, bus.en_D, bus.en_E};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got state=%b busy=%b pc=%b fDEM=%b en_FDE=%b want state=%b busy=%b pc=%b fDEM=%b en_FDE=%b",
                 $time, act[10:9], act[8], act[7:6], act[5:3], act[2:0],
                 exp_v[10:9], exp_v[8], exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.stall_req = 0; bus.md_start = 0; bus.md_div = 0;
    bus.md_use_D = 0; bus.exc_req = 0; bus.eret_D = 0;

    // reset, with noise on the inputs, then idle
    drive(0, 1, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // div issue, then a dependent instruction waits for the full latency
    drive(1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, 1, 0, 0);
    idle(2);

    // exception while waiting, count 6
    drive(1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    idle(8);

    // exception and eret together, then eret alone, then exception during the eret shadow
    drive(1, 0, 0, 0, 0, 1, 1);
    idle(2);
    drive(1, 0, 0, 0, 0, 0, 1);
    idle(2);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1, 0);
    idle(2);

    // second mult issued while busy is ignored
    drive(1, 0, 1, 0, 0, 0, 0);
    idle(2);
    drive(1, 0, 1, 0, 0, 0, 0);
    idle(5);

    // plain load-use stall
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    idle(1);

    // reset in the middle of an md wait, and in the middle of an exception
    drive(1, 0, 1, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 14) == 0,
            $urandom_range(0, 9) == 0);
    end
    idle(2);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: HI/LO busy cycles after a mult/multu issue.
REQ-002 Parameter DIV_CYC, default 10: HI/LO busy cycles after a div/divu issue.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 stall_req  in  1  D-stage data hazard from the Tuse/Tnew comparison.
REQ-006 md_start  in  1  E-stage mult/div issues this cycle.
REQ-007 md_div  in  1  qualifies md_start: 1=div/divu, 0=mult/multu.
REQ-008 md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 exc_req  in  1  exception or interrupt taken at M stage.
REQ-010 eret_D  in  1  eret in D stage.
REQ-011 en_F  out  1  PC/IF-ID write enable.
REQ-012 en_D  out  1  IF-ID register write enable.
REQ-013 en_E  out  1  ID-EX register write enable (i_en).
REQ-014 flush_D, flush_E, flush_M  out  1 each  load nop/cleared fields into IF-ID, ID-EX, EX-MEM.
REQ-015 pc_sel  out  2  next-PC select: 00 sequential/branch, 01 handler 0x00004180, 10 EPC.
REQ-016 md_busy  out  1  HI/LO unit busy.
REQ-017 state  out  2  FSM state for debug: 00 RUN, 01 MDWAIT, 10 EXC, 11 ERET.

Function
REQ-018 Outputs are combinational from state, md counter and inputs; state and counter are registered.
REQ-019 Priority within a cycle: exc_req > eret_D > md hazard > stall_req.
REQ-020 Defaults: en_*=1, flush_*=0, pc_sel=00.
REQ-021 RUN, exc_req=1: flush_D=flush_E=flush_M=1, pc_sel=01, en_*=1; next EXC.
REQ-022 EXC (one cycle): flush_D=1 to kill the wrong-path fetch; exc_req ignored; next RUN.
REQ-023 RUN, eret_D=1 and exc_req=0: pc_sel=10, flush_D=1; next ERET.
REQ-024 ERET (one cycle): flush_D=1; exc_req honoured as in RUN with next EXC; otherwise next RUN.
REQ-025 md hazard = md_use_D & (md_busy | md_start).
REQ-026 RUN, md hazard, no exc_req/eret_D: en_F=en_D=0, en_E=1, flush_E=1; next MDWAIT.
REQ-027 MDWAIT: same stall outputs while md_busy=1; exc_req overrides as REQ-021; leaves to RUN on the cycle md_busy reads 0, with default outputs that cycle.
REQ-028 RUN, stall_req only: en_F=en_D=0, en_E=1, flush_E=1; remain RUN.
REQ-029 Counter is 4-bit; md_start with count==0 loads DIV_CYC if md_div else MULT_CYC.
REQ-030 md_start while count!=0 is ignored (no reload).
REQ-031 Counter decrements by 1 each cycle while nonzero, saturates at 0; md_busy = (count!=0).
REQ-032 exc_req neither clears nor reloads the counter; the in-flight mult/div completes.
REQ-033 flush_E and en_E=1 together mean ID-EX captures a nop; en_E is never 0.

Reset
REQ-034 While reset=0: state=RUN, count=0, so md_busy=0, en_*=1, flush_*=0, pc_sel=00.
REQ-035 Reset asserted mid-MDWAIT or mid-EXC aborts the sequence; first cycle after release is RUN.

Verification
REQ-036 Release reset, idle inputs -> en_*=1, flush_*=0, pc_sel=00, state=00, md_busy=0.
REQ-037 md_start=1, md_div=1; next cycle md_use_D=1 -> md_busy high 10 cycles; en_F=en_D=0, flush_E=1 until count=0; state returns 00.
REQ-038 exc_req=1 during MDWAIT with count=6 -> flush_D/E/M=1, pc_sel=01, state 10 then 00; count keeps decrementing to 0.
REQ-039 exc_req=1 and eret_D=1 same cycle -> pc_sel=01 (exception wins), state 10.
REQ-040 eret_D=1 in RUN -> pc_sel=10, flush_D=1 two cycles (RUN then ERET), state 11 then 00.
REQ-041 md_start with md_div=0, then md_start again on cycle 3 -> second ignored; md_busy falls 5 cycles after the first.
